// File: rtl/bit_order_serializer.sv
// ---------------------------------------------------------------------------
// bit_order_serializer
//
// Parallel-to-serial converter. One WIDTH-bit word is accepted per
// valid/ready handshake. It is then emitted one bit per beat, in a bit order
// that is selected per word:
//   2'b00 : linear, LSB first
//   2'b01 : reverse, MSB first
//   2'b10 : half-interleave (0, W/2, 1, W/2+1, ...)
//   2'b11 : treated as 2'b00
//
// Optional feature macro: BIT_ORDER_SERIALIZER_PARITY_EN
//   When this macro is defined, an extra beat follows the data beats. It
//   carries even parity (the XOR of all captured bits), and out_index is 0
//   on that beat. out_last then marks the parity beat only.
//
// Two-state FSM (IDLE / SHIFT). If a new word is offered on the final beat,
// it is captured on that beat, so consecutive words stream without a bubble.
// in_ready in SHIFT depends combinationally on out_ready. This lets the
// final beat and the next accept share a cycle.
// ---------------------------------------------------------------------------
module bit_order_serializer #(
    parameter int  WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             busy
);

`ifdef BIT_ORDER_SERIALIZER_PARITY_EN
    // The beat counter must also reach beat WIDTH, which is the parity beat.
    localparam int             CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WIDTH);
`else
    localparam int             CNT_W     = IDX_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WIDTH - 1);
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(WIDTH / 2);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   word_q,  word_d;
    logic [1:0]         mode_q,  mode_d;
    logic [CNT_W-1:0]   k_q,     k_d;

    logic               beat_last_s;
    logic               out_fire_s;
    logic               in_fire_s;
    logic [IDX_W-1:0]   idx_s;

    // Map a data beat number to the bit position it reads in the captured word.
    function automatic logic [IDX_W-1:0] src_index(input logic [1:0]       mode,
                                                   input logic [IDX_W-1:0] k);
        logic [IDX_W-1:0] idx;
        idx = k;
        case (mode)
            2'b01:   idx = LAST_IDX - k;
            2'b10:   idx = k[0] ? (HALF_IDX + (k >> 1'd1)) : (k >> 1'd1);
            default: idx = k;
        endcase
        return idx;
    endfunction

`ifdef BIT_ORDER_SERIALIZER_PARITY_EN
    // Even parity over the whole captured word.
    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    // State, captured word/mode and beat counter; reset discards any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= {WIDTH{1'b0}};
            mode_q  <= 2'b00;
            k_q     <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
        end
    end

    // Serial outputs and input-side ready, decoded from the registered state.
    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_bit     = 1'b0;
        out_index   = {IDX_W{1'b0}};
        out_last    = 1'b0;
        busy        = 1'b0;
        idx_s       = src_index(mode_q, k_q[IDX_W-1:0]);
        beat_last_s = (k_q == LAST_BEAT);
        if (state_q == ST_SHIFT) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_last  = beat_last_s;
            in_ready  = out_ready & beat_last_s;
`ifdef BIT_ORDER_SERIALIZER_PARITY_EN
            if (beat_last_s) begin
                out_bit   = even_parity(word_q);
                out_index = {IDX_W{1'b0}};
            end else begin
                out_bit   = word_q[idx_s];
                out_index = idx_s;
            end
`else
            out_bit   = word_q[idx_s];
            out_index = idx_s;
`endif
        end else begin
            // While rst is held, no word is accepted.
            in_ready = ~rst;
        end
    end

    assign out_fire_s = out_valid & out_ready;
    assign in_fire_s  = in_valid & in_ready;

    // Next-state logic: accept in IDLE, advance on each taken beat, chain or retire on the last beat.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        mode_d  = mode_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire_s) begin
                    word_d  = in_data;
                    mode_d  = in_mode;
                    k_d     = {CNT_W{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (out_fire_s) begin
                    if (beat_last_s) begin
                        k_d = {CNT_W{1'b0}};
                        if (in_fire_s) begin
                            word_d  = in_data;
                            mode_d  = in_mode;
                            state_d = ST_SHIFT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        k_d = k_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    k_d = k_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = {CNT_W{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_bit_order_serializer.sv
// Self-checking bench for bit_order_serializer (WIDTH = 8).
// Expected beats are pushed to a scoreboard queue when a word is accepted.
// They are compared against the DUT output while the word is presented.
module tb_bit_order_serializer;

    localparam int W  = 8;
    localparam int IW = 3;
`ifdef BIT_ORDER_SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic          out_bit;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic [4:0]    sb[$];          // {last, index[2:0], bit}
    logic [W-1:0]  obs_bits;
    logic [3*W-1:0] obs_idx;
    int            beat;
    int            last_beat;
    int            n_acc;
    bit            rand_ready;

    bit_order_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_idx(input int m, input int k);
        case (m)
            1:       return W - 1 - k;
            2:       return (k % 2 == 0) ? k / 2 : W / 2 + (k - 1) / 2;
            default: return k;
        endcase
    endfunction

    task automatic push_word(input logic [W-1:0] d, input logic [1:0] m);
        logic [IW-1:0] idx;
        for (int k = 0; k < W; k++) begin
            idx = IW'(model_idx(int'(m), k));
            sb.push_back({(k == NB - 1), idx, d[idx]});
        end
`ifdef BIT_ORDER_SERIALIZER_PARITY_EN
        sb.push_back({1'b1, 3'd0, ^d});
`endif
    endtask

    // One clock cycle, entered just after a falling edge with the inputs already set.
    task automatic cycle();
        logic [4:0] e;
        logic       exp_rdy;
        #4;
        exp_rdy = (sb.size() == 0) ? 1'b1 : ((sb.size() == 1) && out_ready);
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        check_eq("busy", {31'd0, busy}, {31'd0, sb.size() != 0});
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (out_valid && sb.size() != 0) begin
            e = sb[0];
            check_eq("beat", {27'd0, out_last, out_index, out_bit}, {27'd0, e});
            if (out_ready) begin
                void'(sb.pop_front());
                if (beat < W) begin
                    obs_bits[beat]          = out_bit;
                    obs_idx[beat*IW +: IW]  = out_index;
                end
                if (out_last) last_beat = beat;
                beat++;
            end
        end
        if (in_valid && in_ready) begin
            push_word(in_data, in_mode);
            n_acc++;
        end
        @(negedge clk);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run_word(input logic [W-1:0] d, input logic [1:0] m, input bit rnd);
        beat       = 0;
        last_beat  = -1;
        obs_bits   = '0;
        obs_idx    = '0;
        n_acc      = 0;
        rand_ready = rnd;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_data    = d;
        in_mode    = m;
        for (int i = 0; i < 50 && n_acc == 0; i++) cycle();
        check_eq("accept", n_acc, 1);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_mode  = 2'($urandom_range(0, 3));
        for (int i = 0; i < 300 && sb.size() != 0; i++) cycle();
        check_eq("drain", sb.size(), 0);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        cycle();
        check_eq("last_at", last_beat, NB - 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_mode    = 2'b00;
        out_ready  = 1'b1;
        rand_ready = 1'b0;
        n_acc      = 0;
        beat       = 0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_out_bit", {31'd0, out_bit}, 32'd0);
        check_eq("rst_out_index", {29'd0, out_index}, 32'd0);
        check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
        rst = 1'b0;
        cycle();

        run_word(8'hB4, 2'b00, 1'b0);
        check_eq("lin_bits", obs_bits, 8'hB4);
        check_eq("lin_order", obs_idx, 24'hFAC688);

        run_word(8'hB4, 2'b01, 1'b0);
        check_eq("rev_bits", obs_bits, 8'h2D);
        check_eq("rev_order", obs_idx, 24'h053977);

        run_word(8'h0F, 2'b10, 1'b0);
        check_eq("ilv_bits", obs_bits, 8'h55);
        check_eq("ilv_order", obs_idx, 24'hEF2A60);

        run_word(8'h0F, 2'b11, 1'b0);
        check_eq("m11_bits", obs_bits, 8'h0F);
        check_eq("m11_order", obs_idx, 24'hFAC688);

        run_word(8'hA5, 2'b10, 1'b1);
        check_eq("stall_bits", obs_bits, 8'h99);
        check_eq("stall_order", obs_idx, 24'hEF2A60);

        run_word(8'hA5, 2'b00, 1'b1);
        check_eq("stall_lin_bits", obs_bits, 8'hA5);

        // Back-to-back words with in_valid held high: every cycle must carry a beat.
        beat       = 0;
        n_acc      = 0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hFF;
        in_mode    = 2'b00;
        cycle();
        in_data = 8'h00;
        for (int i = 0; i < 2 * NB; i++) begin
            cycle();
            if (n_acc >= 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check_eq("b2b_beats", beat, 2 * NB);
        check_eq("b2b_accepts", n_acc, 2);
        for (int i = 0; i < 50 && sb.size() != 0; i++) cycle();
        check_eq("b2b_drain", sb.size(), 0);
        cycle();

        // Reset in the middle of a word, with three beats already taken.
        n_acc    = 0;
        in_valid = 1'b1;
        in_data  = 8'hB4;
        in_mode  = 2'b00;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        cycle();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_out_index", {29'd0, out_index}, 32'd0);
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        run_word(8'hB4, 2'b00, 1'b0);
        check_eq("post_rst_bits", obs_bits, 8'hB4);
        check_eq("post_rst_order", obs_idx, 24'hFAC688);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
